// File: rtl/uart_fifo_scheduler.sv
// Peripheral-side buffering for the byte UART core: TX/RX FIFOs behind a two-register
// bus port, one TX request per frame slot, RX capture on the core's data-ready rising edge.
//
// state  | meaning
// IDLE   | slot free; launch the TX head byte as soon as the TX FIFO holds data
// WAIT   | frame in flight; slot timer counting down to the next free slot
module uart_fifo_scheduler #(
   parameter int DEPTH        = 8,
   parameter int FRAME_CYCLES = 104024
) (
   input  logic       s_clk_i,
   input  logic       s_resetn_i,
   input  logic       s_wr_i,
   input  logic       s_rd_i,
   input  logic       s_addr_i,
   input  logic [7:0] s_wdata_i,
   output logic [7:0] s_rdata_o,
   input  logic [7:0] s_uart_data_i,
   input  logic       s_uart_ready_i,
   output logic       s_uart_request_o,
   output logic [7:0] s_uart_data_o,
   output logic       s_irq_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(FRAME_CYCLES + 1);
   localparam logic [TW-1:0] FRAME_LD = TW'(FRAME_CYCLES);
   localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   logic [7:0]    r_tx_mem [DEPTH];
   logic [7:0]    r_rx_mem [DEPTH];
   logic [AW:0]   r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
   logic          r_tx_ovf, r_rx_ovf, r_ready_q;
   logic [7:0]    r_rdata, r_tx_data;
   logic          r_req;
   state_t        r_state;
   logic [TW-1:0] r_timer;

   state_t        w_state_nxt;
   logic [TW-1:0] w_timer_nxt;
   logic          w_tx_pop;
   logic          w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
   logic          w_wr_data, w_wr_stat, w_rd_data, w_rd_stat;
   logic          w_tx_push, w_tx_drop, w_rx_edge, w_rx_pop, w_rx_push, w_rx_drop;
   logic [7:0]    w_status, w_tx_head, w_rx_head;

   assign w_tx_empty = (r_tx_wp == r_tx_rp);
   assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
   assign w_rx_empty = (r_rx_wp == r_rx_rp);
   assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
   assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];
   assign w_rx_head  = r_rx_mem[r_rx_rp[AW-1:0]];

   // a write strobe masks a coincident read
   assign w_wr_data = s_wr_i & ~s_addr_i;
   assign w_wr_stat = s_wr_i &  s_addr_i;
   assign w_rd_data = s_rd_i & ~s_wr_i & ~s_addr_i;
   assign w_rd_stat = s_rd_i & ~s_wr_i &  s_addr_i;

   // a same-cycle pop frees the slot, so a push into a full FIFO still lands
   assign w_tx_push = w_wr_data & (~w_tx_full | w_tx_pop);
   assign w_tx_drop = w_wr_data &   w_tx_full & ~w_tx_pop;
   assign w_rx_edge = s_uart_ready_i & ~r_ready_q;
   assign w_rx_pop  = w_rd_data & ~w_rx_empty;
   assign w_rx_push = w_rx_edge & (~w_rx_full | w_rx_pop);
   assign w_rx_drop = w_rx_edge &   w_rx_full & ~w_rx_pop;

   assign w_status = {3'b000, r_tx_ovf, r_rx_ovf, w_tx_full, w_tx_empty, ~w_rx_empty};

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_tx_pop    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_tx_empty) begin
               w_tx_pop    = 1'b1;
               w_timer_nxt = FRAME_LD;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // leave one cycle early so request pulses land FRAME_CYCLES+1 clocks apart
            if (r_timer == TW'(1) || r_timer == '0) begin
               w_timer_nxt = '0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_timer_nxt = r_timer - TW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         r_state   <= ST_IDLE;
         r_timer   <= '0;
         r_req     <= 1'b0;
         r_tx_data <= 8'h00;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_req   <= w_tx_pop;
         if (w_tx_pop) r_tx_data <= w_tx_head;
      end
   end

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         r_tx_wp   <= '0;
         r_tx_rp   <= '0;
         r_rx_wp   <= '0;
         r_rx_rp   <= '0;
         r_tx_ovf  <= 1'b0;
         r_rx_ovf  <= 1'b0;
         r_ready_q <= 1'b0;
         r_rdata   <= 8'h00;
      end else begin
         r_ready_q <= s_uart_ready_i;
         if (w_tx_push) r_tx_wp <= r_tx_wp + PTR_ONE;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + PTR_ONE;
         if (w_rx_push) r_rx_wp <= r_rx_wp + PTR_ONE;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + PTR_ONE;
         if (w_tx_drop)                      r_tx_ovf <= 1'b1;
         else if (w_wr_stat && s_wdata_i[1]) r_tx_ovf <= 1'b0;
         if (w_rx_drop)                      r_rx_ovf <= 1'b1;
         else if (w_wr_stat && s_wdata_i[0]) r_rx_ovf <= 1'b0;
         if (w_rd_stat)      r_rdata <= w_status;
         else if (w_rd_data) r_rdata <= w_rx_empty ? 8'h00 : w_rx_head;
      end
   end

   always_ff @(posedge s_clk_i) begin
      if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= s_wdata_i;
      if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= s_uart_data_i;
   end

   assign s_rdata_o        = r_rdata;
   assign s_uart_request_o = r_req;
   assign s_uart_data_o    = r_tx_data;
   assign s_irq_o          = ~w_rx_empty | r_rx_ovf;
endmodule
